// File: rtl/switch_debouncer.sv
// Multi-channel switch synchronizer and debouncer feeding the switch PIO in_port.
// Optional glitch counter enabled by defining SWITCH_DEBOUNCE_GLITCH_CNT_EN.
module switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    input  logic             glitch_clr,
    output logic [15:0]      glitch_count,
`endif
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [WIDTH-1:0] abort;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;
            logic                   clean_reg;
            logic                   clean_next;
            logic                   rise_reg;
            logic                   rise_next;
            logic                   fall_reg;
            logic                   fall_next;
            logic                   sync_bit;
            logic [0:0]             state;

            // Shift toward the MSB; the MSB is the fully synchronized sample.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_raw[gi]};
                end
            end

            assign sync_bit = sync_reg[SYNC_STAGES-1];
            assign state    = (sync_bit != clean_reg) ? ST_PENDING : ST_STABLE;

            always_comb begin
                cnt_next   = '0;
                clean_next = clean_reg;
                rise_next  = 1'b0;
                fall_next  = 1'b0;
                case (state)
                    ST_PENDING: begin
                        if (cnt_reg == CNT_LAST) begin
                            clean_next = sync_bit;
                            rise_next  = sync_bit;
                            fall_next  = ~sync_bit;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        cnt_next = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg   <= '0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    clean_reg <= clean_next;
                    rise_reg  <= rise_next;
                    fall_reg  <= fall_next;
                end
            end

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
            // A nonzero count while back in STABLE means the mismatch ended before acceptance.
            assign abort[gi] = (state == ST_STABLE) && (cnt_reg != '0);
`endif

            assign sw_clean[gi] = clean_reg;
            assign sw_rise[gi]  = rise_reg;
            assign sw_fall[gi]  = fall_reg;
        end
    endgenerate

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [15:0] glitch_count_reg;
    logic [15:0] glitch_count_next;

    always_comb begin
        glitch_count_next = glitch_count_reg;
        if (glitch_clr) begin
            glitch_count_next = '0;
        end else if ((|abort) && (glitch_count_reg != 16'hFFFF)) begin
            glitch_count_next = glitch_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_count_reg <= '0;
        end else begin
            glitch_count_reg <= glitch_count_next;
        end
    end

    assign glitch_count = glitch_count_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Glitch-counter steps run only when SWITCH_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_switch_debouncer;

    logic       clk;
    logic       reset_n;
    logic [9:0] sw_raw;
    logic [9:0] sw_clean;
    logic [9:0] sw_rise;
    logic [9:0] sw_fall;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic        glitch_clr;
    logic [15:0] glitch_count;
`endif

    int total;
    int bad;

    switch_debouncer #(
        .WIDTH           (10),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (20)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr   (glitch_clr),
        .glitch_count (glitch_count),
`endif
        .sw_clean     (sw_clean),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n active edges; leaves time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw was just changed from a level giving old_c to one giving new_c; clean moves on edge 6.
    task automatic watch(input string tag, input logic [9:0] old_c, input logic [9:0] new_c, input int n);
        logic [9:0] ec, er, ef;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            ec = (k >= 6) ? new_c : old_c;
            er = (k == 6) ? (new_c & ~old_c) : 10'h000;
            ef = (k == 6) ? (old_c & ~new_c) : 10'h000;
            chk({tag, "_clean"}, {22'd0, sw_clean}, {22'd0, ec});
            chk({tag, "_rise"},  {22'd0, sw_rise},  {22'd0, er});
            chk({tag, "_fall"},  {22'd0, sw_fall},  {22'd0, ef});
        end
        $display("[%0t] %s clean=%h rise=%h fall=%h", $time, tag, sw_clean, sw_rise, sw_fall);
    endtask

    // Expect outputs to stay at clean=c with no pulses for n edges.
    task automatic quiet(input string tag, input logic [9:0] c, input int n);
        for (int k = 1; k <= n; k++) begin
            tick(1);
            chk({tag, "_clean"}, {22'd0, sw_clean}, {22'd0, c});
            chk({tag, "_pulse"}, {12'd0, sw_rise, sw_fall}, 32'd0);
        end
        $display("[%0t] %s clean=%h rise=%h fall=%h", $time, tag, sw_clean, sw_rise, sw_fall);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        sw_raw  = 10'h000;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif

        // 1: reset state, then single channel rise
        tick(3);
        chk("rst_outputs", {2'd0, sw_clean, sw_rise, sw_fall}, 32'd0);
        reset_n = 1'b1;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch", {16'd0, glitch_count}, 32'd0);
`endif
        quiet("idle", 10'h000, 20);
        sw_raw = 10'h001;
        watch("ch0_rise", 10'h000, 10'h001, 8);

        // 2: bounce on channel 3, then settle high
        for (int b = 0; b < 4; b++) begin
            sw_raw[3] = (b % 2 == 0) ? 1'b1 : 1'b0;
            quiet("ch3_bounce", 10'h001, 2);
        end
        sw_raw[3] = 1'b1;
        watch("ch3_settle", 10'h001, 10'h009, 8);

        // 3: all channels high, then all fall together
        sw_raw = 10'h3FF;
        watch("all_high", 10'h009, 10'h3FF, 8);
        sw_raw = 10'h000;
        watch("all_fall", 10'h3FF, 10'h000, 8);

        // 4: three-cycle pulse on channel 5 is rejected
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("glitch_cleared", {16'd0, glitch_count}, 32'd0);
`endif
        sw_raw = 10'h020;
        quiet("ch5_pulse", 10'h000, 3);
        sw_raw = 10'h000;
        quiet("ch5_after", 10'h000, 8);
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_one", {16'd0, glitch_count}, 32'd1);
`endif

        // 5: asynchronous reset mid-count on channel 2
        sw_raw = 10'h081;
        watch("pre_rst", 10'h000, 10'h081, 8);
        sw_raw = 10'h085;
        quiet("ch2_count", 10'h081, 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst", {2'd0, sw_clean, sw_rise, sw_fall}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        watch("post_rst", 10'h000, 10'h085, 8);
        sw_raw = 10'h000;
        watch("post_rst_fall", 10'h085, 10'h000, 8);

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        // 6: saturate via anti-phase toggling on channels 6 and 7, then clear vs glitch
        chk("glitch_after_rst", {16'd0, glitch_count}, 32'd0);
        for (int c = 0; c < 70000; c++) begin
            sw_raw[6] = c[0];
            sw_raw[7] = ~c[0];
            tick(1);
        end
        sw_raw = 10'h000;
        tick(8);
        chk("glitch_sat", {16'd0, glitch_count}, 32'h0000FFFF);
        chk("toggle_clean", {22'd0, sw_clean}, 32'd0);
        $display("[%0t] saturate glitch_count=%h", $time, glitch_count);
        sw_raw[8] = 1'b1;
        tick(1);
        sw_raw[8] = 1'b0;
        tick(6);
        chk("glitch_hold", {16'd0, glitch_count}, 32'h0000FFFF);
        // One-edge pulse: mismatch on edge 3, abort on edge 4; clear lands on edge 4.
        sw_raw[8] = 1'b1;
        tick(1);
        sw_raw[8] = 1'b0;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("clr_priority", {16'd0, glitch_count}, 32'd0);
        tick(2);
        chk("clr_stays", {16'd0, glitch_count}, 32'd0);
        $display("[%0t] clear glitch_count=%h", $time, glitch_count);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Multi-channel synchronizer and debouncer for the board slide switches. It sits directly upstream of the switch PIO: raw pins go in, and sw_clean drives the PIO in_port. Each channel's clean level changes only after its synchronized input has held a new value for DEBOUNCE_CYCLES consecutive clocks. This keeps the PIO edge-capture/IRQ logic from seeing contact bounce.

Parameters:
WIDTH, 10, number of switch channels
SYNC_STAGES, 2, flip-flops in each input synchronizer chain (legal range 2..4)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a change (10 ms at 50 MHz; legal range 1..2^CNT_W-1)
CNT_W, 20, per-channel stability counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sw_raw  in  WIDTH  raw asynchronous switch pins
sw_clean  out  WIDTH  debounced level; feeds the PIO in_port
sw_rise  out  WIDTH  one-cycle pulse per channel when sw_clean goes 0->1
sw_fall  out  WIDTH  one-cycle pulse per channel when sw_clean goes 1->0

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. While reset_n is low, every register clears: synchronizer flops, counters, sw_clean, sw_rise, sw_fall.
- Asserting reset mid-count discards that count. After release, a channel whose raw level is 1 debounces up normally (full latency) and produces a sw_rise pulse.
- Synchronizer: per channel, a chain of SYNC_STAGES flops. sync[i] is the last stage. There is no combinational path from sw_raw to any output.
- Each channel is an independent 2-state machine:
  - STABLE (sync[i] == sw_clean[i]): counter held at 0.
  - PENDING (sync[i] != sw_clean[i]): counter increments by 1 each clock.
  - PENDING -> STABLE (abort): if sync[i] returns to sw_clean[i] before the count completes, the counter clears to 0 on the next edge. This is a glitch.
  - PENDING -> accept: on the edge where the counter == DEBOUNCE_CYCLES-1 and the mismatch still holds, sw_clean[i] <= sync[i] and the counter clears to 0.
- Latency: if sw_raw changes and then holds, sw_clean updates exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new raw value. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches sw_clean.
- With DEBOUNCE_CYCLES=1, sw_clean updates on the first edge after the synchronized mismatch appears.
- sw_rise and sw_fall are registered. Each is high for exactly the one cycle in which the new sw_clean value is first visible. sw_rise[i] and sw_fall[i] are never high together.
- Simultaneous changes on several channels are handled independently, with no arbitration; multiple rise/fall bits may be set in the same cycle.
- Counter arithmetic: unsigned CNT_W bits. The counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.

Optional Feature:
Macro SWITCH_DEBOUNCE_GLITCH_CNT_EN.
- Defined, this adds two ports:
  - glitch_clr  in  1  synchronous clear of the glitch counter
  - glitch_count  out  16  number of abort events
- glitch_count increments by 1 in any cycle where at least one channel aborts (PENDING -> STABLE without accept). It saturates at 16'hFFFF.
- glitch_clr has priority over increment. Reset value is 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
Bench parameters: WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset with sw_raw=10'h000 -> sw_clean=0 and sw_rise=sw_fall=0 for 20 cycles. Then sw_raw[0]=1 held -> sw_clean[0]=1 exactly 6 edges after the first sampling edge, with sw_rise[0] high for 1 cycle.
2. sw_raw[3] bounces 1,0,1,0 (2 cycles each), then holds 1 -> no change on sw_clean[3] during the bounce; it goes to 1 at 6 edges after the final stable edge, with exactly one sw_rise[3] pulse.
3. sw_raw 10'h3FF -> 10'h000 in one step from clean=10'h3FF -> all bits fall together after 6 edges; sw_fall=10'h3FF for 1 cycle; sw_rise stays 0.
4. A 3-cycle high pulse on sw_raw[5] -> sw_clean[5] stays 0 and no pulses occur. With the macro defined, glitch_count goes from 0 to 1.
5. reset_n asserted low while channel 2 counter=2 -> all outputs 0 immediately, asynchronously. After release with sw_raw[2]=1 held, sw_clean[2]=1 after the full 6 edges.
6. Macro defined: force glitch_count to 16'hFFFF via repeated short pulses (or preload in sim), then one more glitch -> stays 16'hFFFF. glitch_clr asserted in the same cycle as a glitch -> glitch_count=0.
